// File: rtl/deparser_pkg.sv
// Shared deparser/parser definitions: bus widths, the absent-header marker and
// the deparser state encoding.
package deparser_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;

  // Offset value marking a header slot the parser did not find
  localparam logic [DATA_W-1:0] NO_HEADER = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/deparser_hdr_sel.sv
// Combinational header finder over a presence mask.
//   mask_i   : one bit per header slot, set when the slot has bytes to emit
//   from_i   : lowest id to consider (may equal NUM_HEADERS, meaning none)
//   found_o  : a present slot with id >= from_i exists
//   id_o     : lowest such id
//   hi_id_o  : highest present id in the whole mask
module deparser_hdr_sel #(
  parameter int unsigned NUM_HEADERS = 2,
  parameter int unsigned IDW         = 1
) (
  input  logic [NUM_HEADERS-1:0] mask_i,
  input  logic [IDW:0]           from_i,
  output logic                   found_o,
  output logic [IDW-1:0]         id_o,
  output logic [IDW-1:0]         hi_id_o
);

  localparam int unsigned FW = IDW + 1;

  // Ascending scan: the first hit at or above from_i wins, the last hit overall is hi_id_o
  always_comb begin
    found_o = 1'b0;
    id_o    = '0;
    hi_id_o = '0;
    for (int i = 0; i < NUM_HEADERS; i++) begin
      if (mask_i[i] && !found_o && (FW'(i) >= from_i)) begin
        found_o = 1'b1;
        id_o    = IDW'(i);
      end
      if (mask_i[i]) begin
        hi_id_o = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/deparser.sv
// Packet deparser: serialises the present headers of a latched header buffer
// as a byte stream, in ascending header id order.
//   clk, rst                 : clock, asynchronous active-low reset
//   start_i                  : deparse request (accepted in FREE)
//   pkt_hdr_i, parsed_hdrs_i : header byte buffer and per-slot byte offsets
//   mod_start_i/_hdr_id_i/_hdr_len_i : header-length table write (FREE only)
//   byte_o, valid_o, last_o, ready_i : byte stream with backpressure
//   ready_o, len_o, err_o    : packet complete, bytes emitted, truncation seen
module deparser
  import deparser_pkg::*;
#(
  parameter int unsigned NUM_HEADERS = 2,
  parameter int unsigned HDR_MAX_LEN = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0]   pkt_hdr_i,
  input  logic [NUM_HEADERS-1:0][DATA_W-1:0]   parsed_hdrs_i,
  input  logic                                 mod_start_i,
  input  logic [DATA_W-1:0]                    mod_hdr_id_i,
  input  logic [DATA_W-1:0]                    mod_hdr_len_i,
  output logic [BYTE_W-1:0]                    byte_o,
  output logic                                 valid_o,
  output logic                                 last_o,
  input  logic                                 ready_i,
  output logic                                 ready_o,
  output logic [CNT_W-1:0]                     len_o,
  output logic                                 err_o
);

  localparam int unsigned IDW = (NUM_HEADERS > 1) ? $clog2(NUM_HEADERS) : 1;
  localparam int unsigned FW  = IDW + 1;
  localparam int unsigned AW  = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;

  state_e                               state_q;
  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0]   hdr_q;
  logic [NUM_HEADERS-1:0][DATA_W-1:0]   offs_q;
  logic [NUM_HEADERS-1:0][DATA_W-1:0]   lens_q;
  logic [NUM_HEADERS-1:0]               mask_q;
  logic [IDW-1:0]                       last_id_q;
  logic [IDW-1:0]                       cur_id_q;
  logic [DATA_W-1:0]                    k_q;

  logic [NUM_HEADERS-1:0] mask_new;
  logic                   err_new;
  logic [NUM_HEADERS-1:0] sel_mask;
  logic [FW-1:0]          sel_from;
  logic                   sel_found;
  logic [IDW-1:0]         sel_id;
  logic [IDW-1:0]         sel_hi;

  logic [IDW-1:0]         cand_id;
  logic [DATA_W-1:0]      cand_k;
  logic [DATA_W-1:0]      cand_off;
  logic [DATA_W-1:0]      cand_addr;
  logic [BYTE_W-1:0]      cand_byte;
  logic [IDW-1:0]         tail_id;
  logic                   nat_last;
  logic                   at_end;
  logic                   cand_last;
  logic                   cand_trunc;

  // Slots with bytes to emit; an offset outside the buffer can never be emitted and counts as truncation
  always_comb begin
    mask_new = '0;
    err_new  = 1'b0;
    for (int i = 0; i < NUM_HEADERS; i++) begin
      if ((parsed_hdrs_i[i] != NO_HEADER) && (lens_q[i] != '0)) begin
        if (parsed_hdrs_i[i] < DATA_W'(HDR_MAX_LEN)) mask_new[i] = 1'b1;
        else                                         err_new     = 1'b1;
      end
    end
  end

  // In FREE search the incoming packet from id 0; in EMIT search past the current header
  always_comb begin
    sel_mask = (state_q == FREE) ? mask_new : mask_q;
    sel_from = (state_q == FREE) ? '0 : FW'(cur_id_q) + FW'(1);
  end

  deparser_hdr_sel #(
    .NUM_HEADERS (NUM_HEADERS),
    .IDW         (IDW)
  ) u_hdr_sel (
    .mask_i  (sel_mask),
    .from_i  (sel_from),
    .found_o (sel_found),
    .id_o    (sel_id),
    .hi_id_o (sel_hi)
  );

  // Next byte to present: same header k+1, or byte 0 of the next present header
  always_comb begin
    cand_id = cur_id_q;
    cand_k  = k_q + DATA_W'(1);
    if ((state_q == FREE) || (cand_k >= lens_q[cur_id_q])) begin
      cand_id = sel_id;
      cand_k  = '0;
    end
    cand_off   = (state_q == FREE) ? parsed_hdrs_i[cand_id] : offs_q[cand_id];
    cand_addr  = cand_off + cand_k;
    cand_byte  = (state_q == FREE) ? pkt_hdr_i[AW'(cand_addr)] : hdr_q[AW'(cand_addr)];
    tail_id    = (state_q == FREE) ? sel_hi : last_id_q;
    nat_last   = (cand_id == tail_id) && ((cand_k + DATA_W'(1)) == lens_q[cand_id]);
    at_end     = (cand_addr == DATA_W'(HDR_MAX_LEN - 1));
    cand_last  = nat_last || at_end;
    cand_trunc = at_end && !nat_last;
  end

  // State machine with registered stream and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FREE;
      hdr_q     <= '0;
      offs_q    <= '0;
      lens_q    <= '0;
      mask_q    <= '0;
      last_id_q <= '0;
      cur_id_q  <= '0;
      k_q       <= '0;
      byte_o    <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      ready_o   <= 1'b0;
      len_o     <= '0;
      err_o     <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          if (mod_start_i) begin
            if (mod_hdr_id_i < DATA_W'(NUM_HEADERS)) lens_q[IDW'(mod_hdr_id_i)] <= mod_hdr_len_i;
          end else if (start_i) begin
            hdr_q     <= pkt_hdr_i;
            offs_q    <= parsed_hdrs_i;
            mask_q    <= mask_new;
            last_id_q <= sel_hi;
            len_o     <= '0;
            if (sel_found) begin
              state_q  <= EMIT;
              cur_id_q <= cand_id;
              k_q      <= cand_k;
              byte_o   <= cand_byte;
              valid_o  <= 1'b1;
              last_o   <= cand_last;
              ready_o  <= 1'b0;
              err_o    <= err_new | cand_trunc;
            end else begin
              state_q  <= DONE;
              ready_o  <= 1'b1;
              err_o    <= err_new;
            end
          end
        end
        EMIT: begin
          if (valid_o && ready_i) begin
            if (len_o != '1) len_o <= len_o + CNT_W'(1);
            if (last_o) begin
              state_q <= DONE;
              valid_o <= 1'b0;
              last_o  <= 1'b0;
              ready_o <= 1'b1;
            end else begin
              cur_id_q <= cand_id;
              k_q      <= cand_k;
              byte_o   <= cand_byte;
              last_o   <= cand_last;
              err_o    <= err_o | cand_trunc;
            end
          end
        end
        DONE: begin
          if (!start_i) state_q <= FREE;
        end
        default: state_q <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_deparser.sv
// Directed self-checking bench for the deparser.
module tb_deparser;
  import deparser_pkg::*;

  localparam int unsigned NH  = 2;
  localparam int unsigned HML = 64;
  localparam int unsigned CW  = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start_i = 1'b0;
  logic [HML-1:0][7:0]     pkt_hdr_i;
  logic [NH-1:0][31:0]     parsed_hdrs_i;
  logic                    mod_start_i = 1'b0;
  logic [31:0]             mod_hdr_id_i = '0;
  logic [31:0]             mod_hdr_len_i = '0;
  logic [7:0]              byte_o;
  logic                    valid_o;
  logic                    last_o;
  logic                    ready_i = 1'b1;
  logic                    ready_o;
  logic [CW-1:0]           len_o;
  logic                    err_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  deparser #(
    .NUM_HEADERS (NH),
    .HDR_MAX_LEN (HML),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .pkt_hdr_i     (pkt_hdr_i),
    .parsed_hdrs_i (parsed_hdrs_i),
    .mod_start_i   (mod_start_i),
    .mod_hdr_id_i  (mod_hdr_id_i),
    .mod_hdr_len_i (mod_hdr_len_i),
    .byte_o        (byte_o),
    .valid_o       (valid_o),
    .last_o        (last_o),
    .ready_i       (ready_i),
    .ready_o       (ready_o),
    .len_o         (len_o),
    .err_o         (err_o)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_buf(input bit inv);
    for (int i = 0; i < HML; i++) pkt_hdr_i[i] = inv ? ~pat(i) : pat(i);
  endtask

  task automatic set_len(input int id, input int len);
    mod_start_i   = 1'b1;
    mod_hdr_id_i  = 32'(id);
    mod_hdr_len_i = 32'(len);
    @(negedge clk);
    mod_start_i   = 1'b0;
  endtask

  task automatic add_range(input int off, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(pat(off + k));
  endtask

  // Buffer is scrambled after acceptance so any unlatched read shows up
  task automatic start_pkt(input logic [31:0] o0, input logic [31:0] o1);
    fill_buf(1'b0);
    parsed_hdrs_i[0] = o0;
    parsed_hdrs_i[1] = o1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    fill_buf(1'b1);
  endtask

  // Consume n_take bytes; with stall, ready_i follows 1,0,0,1 then stays high
  task automatic stream(input int n_take, input bit stall, input string tag);
    int got = 0;
    int cyc = 0;
    int total = exp_q.size();
    bit prev_stall = 1'b0;
    logic [7:0] held = '0;
    logic held_last = 1'b0;
    while (got < n_take && cyc < 200) begin
      ready_i = (stall && (cyc == 1 || cyc == 2)) ? 1'b0 : 1'b1;
      chk({tag, "_valid"}, 32'(valid_o), 32'd1);
      if (prev_stall) begin
        chk({tag, "_hold_byte"}, 32'(byte_o), 32'(held));
        chk({tag, "_hold_last"}, 32'(last_o), 32'(held_last));
      end
      if (valid_o && ready_i) begin
        chk({tag, "_byte"}, 32'(byte_o), 32'(exp_q[got]));
        chk({tag, "_last"}, 32'(last_o), 32'(got == total - 1));
        got++;
      end
      prev_stall = valid_o && !ready_i;
      held = byte_o;
      held_last = last_o;
      @(negedge clk);
      cyc++;
    end
    ready_i = 1'b1;
    chk({tag, "_count"}, 32'(got), 32'(n_take));
  endtask

  initial begin
    fill_buf(1'b0);
    parsed_hdrs_i[0] = NO_HEADER;
    parsed_hdrs_i[1] = NO_HEADER;

    // Reset state
    #12;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_last",  32'(last_o),  32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_len",   32'(len_o),   32'd0);
    chk("rst_err",   32'(err_o),   32'd0);
    chk("rst_byte",  32'(byte_o),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    set_len(0, 14);
    set_len(1, 20);

    // Two headers back to back, full throughput
    exp_q.delete();
    add_range(0, 14);
    add_range(14, 20);
    start_pkt(32'd0, 32'd14);
    stream(34, 1'b0, "t1");
    chk("t1_end_valid", 32'(valid_o), 32'd0);
    chk("t1_ready",     32'(ready_o), 32'd1);
    chk("t1_len",       32'(len_o),   32'd34);
    chk("t1_err",       32'(err_o),   32'd0);

    // Table write while in DONE must be dropped
    mod_start_i   = 1'b1;
    mod_hdr_id_i  = 32'd1;
    mod_hdr_len_i = 32'd3;
    @(negedge clk);
    mod_start_i   = 1'b0;
    chk("free_ready_hold", 32'(ready_o), 32'd1);

    // Second header absent
    exp_q.delete();
    add_range(0, 14);
    start_pkt(32'd0, NO_HEADER);
    stream(14, 1'b0, "t2");
    chk("t2_ready", 32'(ready_o), 32'd1);
    chk("t2_len",   32'(len_o),   32'd14);
    @(negedge clk);

    // Backpressure during header 0; header 1 length must still be 20
    exp_q.delete();
    add_range(0, 14);
    add_range(14, 20);
    start_pkt(32'd0, 32'd14);
    stream(34, 1'b1, "t3");
    chk("t3_ready", 32'(ready_o), 32'd1);
    chk("t3_len",   32'(len_o),   32'd34);
    @(negedge clk);

    // No header present
    start_pkt(NO_HEADER, NO_HEADER);
    chk("t4_valid", 32'(valid_o), 32'd0);
    chk("t4_ready", 32'(ready_o), 32'd1);
    chk("t4_len",   32'(len_o),   32'd0);
    @(negedge clk);
    chk("t4_valid2", 32'(valid_o), 32'd0);

    // Truncation at the end of the buffer
    exp_q.delete();
    add_range(60, 4);
    start_pkt(32'd60, NO_HEADER);
    stream(4, 1'b0, "t5");
    chk("t5_err",   32'(err_o),   32'd1);
    chk("t5_len",   32'(len_o),   32'd4);
    chk("t5_ready", 32'(ready_o), 32'd1);
    @(negedge clk);

    // Reset mid-packet, then a packet with a cleared length table
    exp_q.delete();
    add_range(0, 14);
    add_range(14, 20);
    start_pkt(32'd0, 32'd14);
    stream(5, 1'b0, "t6");
    #2 rst = 1'b0;
    #1;
    chk("t6_async_valid", 32'(valid_o), 32'd0);
    chk("t6_async_len",   32'(len_o),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    start_pkt(32'd0, 32'd14);
    chk("t6_valid", 32'(valid_o), 32'd0);
    chk("t6_ready", 32'(ready_o), 32'd1);
    chk("t6_len",   32'(len_o),   32'd0);
    @(negedge clk);
    chk("t6_valid2", 32'(valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deparser.md
DEPARSER -- requirements
Module: deparser

Interface
REQ-001 SHALL have parameters: NUM_HEADERS, default 2, header slots; HDR_MAX_LEN, default 64, header buffer bytes; CNT_W, default 8, byte-count width.
REQ-002 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have start_i  input  1  request to deparse one packet.
REQ-005 SHALL have pkt_hdr_i  input  HDR_MAX_LEN x 8  header byte buffer.
REQ-006 SHALL have parsed_hdrs_i  input  NUM_HEADERS x 32  per-header byte offset, or NO_HEADER if absent.
REQ-007 SHALL have mod_start_i / mod_hdr_id_i / mod_hdr_len_i  input  1 / 32 / 32  header-length table write.
REQ-008 SHALL have byte_o / valid_o / last_o  output  8 / 1 / 1  serial byte stream; ready_i  input  1  stream backpressure.
REQ-009 SHALL have ready_o  output  1  packet complete; len_o  output  CNT_W  bytes emitted; err_o  output  1  truncation occurred.

Function
REQ-010 SHALL implement states FREE, EMIT, DONE.
REQ-011 In FREE, mod_start_i SHALL write hdr_lens[mod_hdr_id_i] and take priority over start_i; ids >= NUM_HEADERS SHALL be ignored.
REQ-012 mod_start_i outside FREE SHALL be ignored.
REQ-013 On start_i in FREE, SHALL latch pkt_hdr_i and parsed_hdrs_i, clear ready_o/err_o/len_o, select the lowest present header id, and go to EMIT.
REQ-014 Headers SHALL be emitted in ascending id order; slots that are NO_HEADER or have hdr_lens = 0 SHALL be skipped.
REQ-015 Within a header, byte k SHALL be pkt_hdr[offset + k] for k = 0 .. hdr_len-1.
REQ-016 A byte SHALL transfer only on a cycle with valid_o and ready_i both high; each transfer SHALL increment len_o by 1.
REQ-017 While valid_o is high and ready_i is low, byte_o and last_o SHALL hold stable.
REQ-018 First valid_o SHALL assert the cycle after start_i is accepted; throughput SHALL be 1 byte per cycle when ready_i is held high, including across header boundaries.
REQ-019 last_o SHALL be high with the final byte of the last emitted header only.
REQ-020 If offset + k reaches HDR_MAX_LEN, SHALL stop emission after byte HDR_MAX_LEN-1, assert last_o on that byte, and set err_o.
REQ-021 If no header is present, SHALL go FREE -> DONE without asserting valid_o, with len_o = 0 and ready_o high.
REQ-022 After the last transfer, SHALL enter DONE with ready_o = 1; len_o and err_o SHALL hold.
REQ-023 In DONE, SHALL return to FREE when start_i is low; ready_o SHALL stay high until the next accepted start_i.
REQ-024 len_o SHALL saturate at 2^CNT_W-1.

Reset
REQ-025 When rst is low, SHALL asynchronously clear: valid_o, last_o, ready_o, err_o, byte_o, len_o, hdr_lens, and all latched data; state = FREE.
REQ-026 Reset asserted in EMIT SHALL drop valid_o immediately; no further bytes SHALL be emitted after release until a new start_i.

Structure
REQ-027 NO_HEADER (32'hFFFF_FFFF), the state enum, and the byte/data bus widths SHALL live in the shared definitions package/header used by the parser.
REQ-028 A sub-module deparser_hdr_sel (combinational next-present-header finder over a presence mask) is natural; all else stays inline.

Verification
REQ-029 hdr_lens={14,20}, offsets={0,14}, ready_i=1, start_i -> 34 consecutive bytes equal to buf[0..33], last_o on byte 33, len_o=34, ready_o=1.
REQ-030 Same config but parsed_hdrs_i[1]=NO_HEADER -> 14 bytes, last_o on byte 13, len_o=14.
REQ-031 ready_i toggling 1,0,0,1 during header 0 -> byte_o held through stall cycles, no byte lost or duplicated.
REQ-032 Both slots NO_HEADER -> valid_o never high, ready_o=1 next cycle, len_o=0.
REQ-033 offset=60, hdr_len=14, HDR_MAX_LEN=64 -> 4 bytes emitted (buf[60..63]), last_o on 4th, err_o=1.
REQ-034 rst low after 5 bytes, then released, start_i -> valid_o drops asynchronously; hdr_lens=0 so packet ends with len_o=0.
